// File: rtl/display_scan_decoder_pkg.sv
// Shared constants, FSM encoding and 7-segment lookup for the scan-bus decoder.
// Pure declarations; no clocked logic, no flow control.
package display_scan_pkg;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_ORDER   = 3'd1;
    localparam logic [2:0] ERR_MULTI   = 3'd2;
    localparam logic [2:0] ERR_BADSEG  = 3'd3;
    localparam logic [2:0] ERR_RANGE   = 3'd4;
    localparam logic [2:0] ERR_TIMEOUT = 3'd5;
    localparam logic [2:0] ERR_DP      = 3'd6;

    localparam logic [1:0] DIG_SU = 2'd0;
    localparam logic [1:0] DIG_ST = 2'd1;
    localparam logic [1:0] DIG_MU = 2'd2;
    localparam logic [1:0] DIG_MT = 2'd3;

    localparam logic [6:0] SEG_0 = 7'h3F;
    localparam logic [6:0] SEG_1 = 7'h06;
    localparam logic [6:0] SEG_2 = 7'h5B;
    localparam logic [6:0] SEG_3 = 7'h4F;
    localparam logic [6:0] SEG_4 = 7'h66;
    localparam logic [6:0] SEG_5 = 7'h6D;
    localparam logic [6:0] SEG_6 = 7'h7D;
    localparam logic [6:0] SEG_7 = 7'h07;
    localparam logic [6:0] SEG_8 = 7'h7F;
    localparam logic [6:0] SEG_9 = 7'h6F;

    // ST_Dk means digit k is staged and digit k+1 is awaited.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_D0   = 2'd1,
        ST_D1   = 2'd2,
        ST_D2   = 2'd3
    } scan_state_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] bcd;
    } seg_dec_t;

    function automatic seg_dec_t seg7_to_bcd(input logic [6:0] seg);
        seg_dec_t dec;
        dec.vld = 1'b1;
        dec.bcd = 4'd0;
        case (seg)
            SEG_0:   dec.bcd = 4'd0;
            SEG_1:   dec.bcd = 4'd1;
            SEG_2:   dec.bcd = 4'd2;
            SEG_3:   dec.bcd = 4'd3;
            SEG_4:   dec.bcd = 4'd4;
            SEG_5:   dec.bcd = 4'd5;
            SEG_6:   dec.bcd = 4'd6;
            SEG_7:   dec.bcd = 4'd7;
            SEG_8:   dec.bcd = 4'd8;
            SEG_9:   dec.bcd = 4'd9;
            default: dec.vld = 1'b0;
        endcase
        return dec;
    endfunction

    function automatic logic [5:0] times10(input logic [3:0] t);
        logic [5:0] w_t;
        w_t = {2'b00, t};
        return (w_t << 3) + (w_t << 1);
    endfunction

endpackage

// File: rtl/display_scan_decoder_seg7.sv
// Strict 7-segment to BCD decoder; any non-digit pattern clears o_vld.
// Combinational, zero latency, no flow control.
module seg7_to_bcd
    import display_scan_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_bcd,
    output logic       o_vld
);

    seg_dec_t w_dec;

    assign w_dec = display_scan_pkg::seg7_to_bcd(i_seg);
    assign o_bcd = w_dec.bcd;
    assign o_vld = w_dec.vld;

endmodule

// File: rtl/display_scan_decoder.sv
// Decodes a 4-digit multiplexed 7-seg scan back to mm:ss; frame_valid/err pulse 1 clk after the last/offending sample.
// No backpressure: the scan bus free-runs. Define DP_CHECK_EN to also check the decimal point on every digit.
module display_scan_decoder
    import display_scan_pkg::*;
#(
    parameter int SETTLE_CYC  = 0,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_seg,
    input  logic       i_dp,
    input  logic [3:0] i_dig_en,
    output logic [5:0] o_seconds,
    output logic [5:0] o_minutes,
    output logic       o_frame_valid,
    output logic       o_err,
    output logic [2:0] o_err_code
);

    localparam int SW = $clog2(SETTLE_CYC + 2);
    localparam int TW = $clog2(TIMEOUT_CYC);

    scan_state_t r_state, w_state_nxt;
    logic [3:0]    r_prev_en;
    logic [SW-1:0] r_hold, w_hold;
    logic [TW-1:0] r_to_cnt;
    logic [3:0]    r_su, r_st, r_mu;
    logic [5:0]    r_seconds, r_minutes;
    logic          r_frame_valid, r_err;
    logic [2:0]    r_err_code;

    logic       w_sample, w_onehot, w_seg_vld, w_dp_ok;
    logic [3:0] w_bcd;
    logic [1:0] w_dig_idx, w_exp_idx;
    logic [2:0] w_dig_code, w_code;
    logic       w_abort, w_stage, w_done, w_to_clr;

    seg7_to_bcd u_dec (
        .i_seg (i_seg),
        .o_bcd (w_bcd),
        .o_vld (w_seg_vld)
    );

    // Hold counter saturates one past the settle point so a long hold samples once.
    assign w_hold   = (i_dig_en != r_prev_en) ? '0 :
                      (r_hold == SW'(SETTLE_CYC + 1)) ? r_hold : r_hold + 1'b1;
    assign w_sample = (i_dig_en != 4'd0) && (w_hold == SW'(SETTLE_CYC));
    assign w_onehot = $onehot(i_dig_en);

`ifdef DP_CHECK_EN
    assign w_dp_ok = (i_dp == (w_dig_idx != DIG_MT));
`else
    logic w_unused_dp;
    assign w_unused_dp = i_dp;
    assign w_dp_ok     = 1'b1;
`endif

    always_comb begin
        w_dig_idx = DIG_SU;
        case (i_dig_en)
            4'b0010: w_dig_idx = DIG_ST;
            4'b0100: w_dig_idx = DIG_MU;
            4'b1000: w_dig_idx = DIG_MT;
            default: w_dig_idx = DIG_SU;
        endcase
    end

    always_comb begin
        w_exp_idx = DIG_SU;
        case (r_state)
            ST_D0:   w_exp_idx = DIG_ST;
            ST_D1:   w_exp_idx = DIG_MU;
            ST_D2:   w_exp_idx = DIG_MT;
            default: w_exp_idx = DIG_SU;
        endcase
    end

    always_comb begin
        w_dig_code = ERR_NONE;
        if (!w_seg_vld)
            w_dig_code = ERR_BADSEG;
        else if ((w_dig_idx == DIG_ST || w_dig_idx == DIG_MT) && w_bcd > 4'd5)
            w_dig_code = ERR_RANGE;
        else if (!w_dp_ok)
            w_dig_code = ERR_DP;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_abort     = 1'b0;
        w_code      = ERR_NONE;
        w_stage     = 1'b0;
        w_done      = 1'b0;
        w_to_clr    = 1'b0;
        if (w_sample) begin
            w_to_clr = 1'b1;
            if (!w_onehot) begin
                w_abort     = 1'b1;
                w_code      = ERR_MULTI;
                w_state_nxt = ST_IDLE;
            end else if (r_state == ST_IDLE) begin
                if (w_dig_idx == DIG_SU) begin
                    if (w_dig_code != ERR_NONE) begin
                        w_abort = 1'b1;
                        w_code  = w_dig_code;
                    end else begin
                        w_stage     = 1'b1;
                        w_state_nxt = ST_D0;
                    end
                end
            end else if (w_dig_idx != w_exp_idx) begin
                // An early units-seconds strobe resynchronises onto a new frame.
                w_abort     = 1'b1;
                w_code      = ERR_ORDER;
                w_stage     = (w_dig_idx == DIG_SU) && (w_dig_code == ERR_NONE);
                w_state_nxt = w_stage ? ST_D0 : ST_IDLE;
            end else if (w_dig_code != ERR_NONE) begin
                w_abort     = 1'b1;
                w_code      = w_dig_code;
                w_state_nxt = ST_IDLE;
            end else begin
                w_stage = 1'b1;
                case (r_state)
                    ST_D0:   w_state_nxt = ST_D1;
                    ST_D1:   w_state_nxt = ST_D2;
                    default: begin
                        w_state_nxt = ST_IDLE;
                        w_done      = 1'b1;
                    end
                endcase
            end
        end else if (r_state != ST_IDLE && r_to_cnt == TW'(TIMEOUT_CYC - 1)) begin
            w_abort     = 1'b1;
            w_code      = ERR_TIMEOUT;
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_prev_en     <= 4'd0;
            r_hold        <= '0;
            r_to_cnt      <= '0;
            r_su          <= 4'd0;
            r_st          <= 4'd0;
            r_mu          <= 4'd0;
            r_seconds     <= 6'd0;
            r_minutes     <= 6'd0;
            r_frame_valid <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= ERR_NONE;
        end else begin
            r_state       <= w_state_nxt;
            r_prev_en     <= i_dig_en;
            r_hold        <= w_hold;
            r_to_cnt      <= (w_to_clr || w_state_nxt == ST_IDLE) ? '0 : r_to_cnt + 1'b1;
            r_frame_valid <= w_done;
            r_err         <= w_abort;
            if (w_stage) begin
                case (w_dig_idx)
                    DIG_SU:  r_su <= w_bcd;
                    DIG_ST:  r_st <= w_bcd;
                    DIG_MU:  r_mu <= w_bcd;
                    default: ;
                endcase
            end
            if (w_abort)
                r_err_code <= w_code;
            if (w_done) begin
                r_seconds <= times10(r_st) + {2'b00, r_su};
                r_minutes <= times10(w_bcd) + {2'b00, r_mu};
            end
        end
    end

    assign o_seconds     = r_seconds;
    assign o_minutes     = r_minutes;
    assign o_frame_valid = r_frame_valid;
    assign o_err         = r_err;
    assign o_err_code    = r_err_code;

endmodule
